sig_ext: RTL and testbench
==========================

# sig_ext

Immediate-field extender for the MIPS single-cycle datapath. Widens the 16-bit instruction immediate to a 32-bit operand for the ALU, address adder and branch-target adder. The primary path is combinational so it fits the single-cycle critical path. An optional pipeline register, selected at compile time, is provided for timing closure.

## Interface
Parameters:
- none. Widths are fixed at 16-bit input and 32-bit output.

Ports:
- clk  input  1  system clock; used only by the optional output register.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  16  immediate field, instr[15:0].
- mode  input  2  extension mode: 00 sign, 01 zero, 10 upper (LUI), 11 branch (sign-extend, then shift left 2).
- valid_in  input  1  qualifies `in` and `mode` for the registered path.
- out  output  32  combinational extended result.
- out_q  output  32  registered result; depends on `SIGEXT_REG_OUT_EN`.
- valid_q  output  1  qualifies `out_q`.

## Operation
Result of `out` for each `mode` value:
- mode 00: out = {{16{in[15]}}, in}. This is the default used by the core for addi/lw/sw/beq offsets.
- mode 01: out = {16'h0000, in}. Used for andi/ori/xori.
- mode 10: out = {in, 16'h0000}. Used for lui.
- mode 11: out = {{14{in[15]}}, in, 2'b00}. Gives a byte offset for the branch adder. Bits shifted out are discarded; no overflow flag.

Rules:
- `out` is a pure function of `in` and `mode`. It has no dependence on `clk` or `rst_n` and never holds X when the inputs are known.
- Sign bit is in[15] only. in = 16'h8000 in mode 00 gives 32'hFFFF8000, the most negative value.
- No arithmetic is performed beyond concatenation and replication. Result width is exactly 32 bits.

## Timing
- `out`: zero-cycle latency, combinational, settles within the same cycle as `in`.
- Reset values: `out_q` = 32'h0000_0000 and `valid_q` = 0 immediately on rst_n falling, independent of `clk`. Both are held while rst_n = 0.
- Reset release: the first capture happens on the first rising `clk` with rst_n = 1.
- Registered path, when enabled: on each rising `clk`, out_q <= out and valid_q <= valid_in.
- `out_q` updates only when valid_in = 1. When valid_in = 0, `out_q` holds its previous value and `valid_q` drops to 0.
- Latency `in` -> `out_q` is 1 cycle.
- Back-to-back valid_in = 1 gives one result per cycle. There is no backpressure.
- Reset asserted mid-operation clears the pending result. No captured value survives reset.

## Configuration
- Macro `SIGEXT_REG_OUT_EN`.
- Defined: the `out_q`/`valid_q` register stage exists exactly as described in Timing.
- Not defined:
  - out_q = out and valid_q = valid_in, combinationally.
  - `clk` and `rst_n` are unused; no flops are inferred.
  - Port list is unchanged so integration code is identical in both builds.

## Test plan
- mode 00, in = 16'h1234 -> out = 32'h00001234. Then in = 16'hFFFF -> 32'hFFFFFFFF. Then in = 16'h0000 -> 32'h00000000.
- mode 00, in = 16'hFFAA -> 32'hFFFFFFAA. Then in = 16'h8000 -> 32'hFFFF8000.
- mode 01, in = 16'hFFAA -> 32'h0000FFAA. mode 10, in = 16'h1234 -> 32'h12340000.
- mode 11: in = 16'hFFFF -> 32'hFFFFFFFC; in = 16'h0004 -> 32'h00000010.
- With `SIGEXT_REG_OUT_EN` defined, rst_n = 0 -> out_q = 0 and valid_q = 0 asynchronously. Then:
  - Release reset, apply valid_in = 1 with in = 16'h8000, mode 00.
  - Next rising edge -> out_q = 32'hFFFF8000, valid_q = 1.
  - Drop valid_in -> out_q holds and valid_q = 0.
- Mid-stream reset: rst_n pulsed low between edges while valid_q = 1 -> out_q and valid_q clear immediately, with no clock edge required.

Source files
------------

// File: rtl/sig_ext.sv
// rtl/sig_ext.sv - MIPS immediate extender; SIGEXT_REG_OUT_EN adds an out_q/valid_q register stage
module sig_ext (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic [1:0]  mode,
  input  logic        valid_in,
  output logic [31:0] out,
  output logic [31:0] out_q,
  output logic        valid_q
);

  typedef enum logic [1:0] {
    EXT_SIGN   = 2'b00,
    EXT_ZERO   = 2'b01,
    EXT_UPPER  = 2'b10,
    EXT_BRANCH = 2'b11
  } ext_mode_t;

  always_comb begin
    out = {{16{in[15]}}, in};
    case (ext_mode_t'(mode))
      EXT_SIGN:   out = {{16{in[15]}}, in};
      EXT_ZERO:   out = {16'h0000, in};
      EXT_UPPER:  out = {in, 16'h0000};
      EXT_BRANCH: out = {{14{in[15]}}, in, 2'b00};
      default:    out = {{16{in[15]}}, in};
    endcase
  end

`ifdef SIGEXT_REG_OUT_EN
  // out_q only loads on valid beats; valid_q follows valid_in every cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_in;
      if (valid_in) begin
        out_q <= out;
      end
    end
  end
`else
  logic unused_clk_rst;

  assign out_q          = out;
  assign valid_q        = valid_in;
  assign unused_clk_rst = clk ^ rst_n;
`endif

endmodule

// File: tb/tb_sig_ext.sv
// tb/tb_sig_ext.sv - self-checking bench for sig_ext (combinational and SIGEXT_REG_OUT_EN builds)
module tb_sig_ext;

  logic        clk;
  logic        rst_n;
  logic [15:0] in;
  logic [1:0]  mode;
  logic        valid_in;
  logic [31:0] out;
  logic [31:0] out_q;
  logic        valid_q;

  int n_checks;
  int n_fail;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] in;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  sig_ext dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .mode     (mode),
    .valid_in (valid_in),
    .out      (out),
    .out_q    (out_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    vecs[0]  = '{2'b00, 16'h1234, 32'h0000_1234};
    vecs[1]  = '{2'b00, 16'hFFFF, 32'hFFFF_FFFF};
    vecs[2]  = '{2'b00, 16'h0000, 32'h0000_0000};
    vecs[3]  = '{2'b00, 16'hFFAA, 32'hFFFF_FFAA};
    vecs[4]  = '{2'b00, 16'h8000, 32'hFFFF_8000};
    vecs[5]  = '{2'b00, 16'h7FFF, 32'h0000_7FFF};
    vecs[6]  = '{2'b01, 16'hFFAA, 32'h0000_FFAA};
    vecs[7]  = '{2'b01, 16'h8000, 32'h0000_8000};
    vecs[8]  = '{2'b10, 16'h1234, 32'h1234_0000};
    vecs[9]  = '{2'b10, 16'hFFFF, 32'hFFFF_0000};
    vecs[10] = '{2'b11, 16'hFFFF, 32'hFFFF_FFFC};
    vecs[11] = '{2'b11, 16'h0004, 32'h0000_0010};
    vecs[12] = '{2'b11, 16'h8000, 32'hFFFE_0000};
    vecs[13] = '{2'b11, 16'h7FFF, 32'h0001_FFFC};

    rst_n    = 1'b1;
    in       = 16'h0000;
    mode     = 2'b00;
    valid_in = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
`ifdef SIGEXT_REG_OUT_EN
    check("reset_out_q", out_q, 32'h0);
    check("reset_valid_q", {31'h0, valid_q}, 32'h0);

    @(negedge clk);
    rst_n    = 1'b1;
    in       = 16'h8000;
    mode     = 2'b00;
    valid_in = 1'b1;
    #1;
    check("pre_edge_valid_q", {31'h0, valid_q}, 32'h0);
    @(posedge clk);
    #1;
    check("first_capture_out_q", out_q, 32'hFFFF_8000);
    check("first_capture_valid_q", {31'h0, valid_q}, 32'h1);

    @(negedge clk);
    valid_in = 1'b0;
    in       = 16'h1234;
    @(posedge clk);
    #1;
    check("hold_out_q", out_q, 32'hFFFF_8000);
    check("hold_valid_q", {31'h0, valid_q}, 32'h0);
    check("hold_comb_out", out, 32'h0000_1234);
`else
    @(negedge clk);
    rst_n    = 1'b1;
    valid_in = 1'b0;
    in       = 16'h8000;
    #1;
    check("pass_invalid_valid_q", {31'h0, valid_q}, 32'h0);
    check("pass_invalid_out_q", out_q, 32'hFFFF_8000);
`endif

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in       = vecs[i].in;
      mode     = vecs[i].mode;
      valid_in = 1'b1;
      #1;
      check($sformatf("vec%0d_out", i), out, vecs[i].exp);
`ifdef SIGEXT_REG_OUT_EN
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_out_q", i), out_q, vecs[i].exp);
      check($sformatf("vec%0d_valid_q", i), {31'h0, valid_q}, 32'h1);
`else
      check($sformatf("vec%0d_out_q", i), out_q, vecs[i].exp);
      check($sformatf("vec%0d_valid_q", i), {31'h0, valid_q}, 32'h1);
`endif
    end

`ifdef SIGEXT_REG_OUT_EN
    @(negedge clk);
    in       = 16'h1234;
    mode     = 2'b10;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
    check("pre_midreset_out_q", out_q, 32'h1234_0000);
    check("pre_midreset_valid_q", {31'h0, valid_q}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_out_q", out_q, 32'h0);
    check("midreset_valid_q", {31'h0, valid_q}, 32'h0);
    @(posedge clk);
    #1;
    check("reset_held_out_q", out_q, 32'h0);
    check("reset_held_valid_q", {31'h0, valid_q}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    in    = 16'h0004;
    mode  = 2'b11;
    @(posedge clk);
    #1;
    check("post_reset_out_q", out_q, 32'h0000_0010);
    check("post_reset_valid_q", {31'h0, valid_q}, 32'h1);
`else
    @(negedge clk);
    rst_n    = 1'b0;
    in       = 16'h0004;
    mode     = 2'b11;
    valid_in = 1'b1;
    #1;
    check("comb_in_reset_out", out, 32'h0000_0010);
    check("comb_in_reset_out_q", out_q, 32'h0000_0010);
    check("comb_in_reset_valid_q", {31'h0, valid_q}, 32'h1);
    rst_n = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
